// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared state encodings and port indices for the RAM arbiter
package ram_arbiter_pkg;

  localparam int DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_READ   = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

endpackage

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - one requester's transaction handshake toward the RAM arbiter
interface ram_arbiter_if #(
  parameter int ADDR_WIDTH = 12
) ();

  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            wdata;
  logic                  ack;
  logic [7:0]            rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );

endinterface

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-way picker, round-robin or fixed port-0 priority
module rr_arbiter2
  import ram_arbiter_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_grant,
  input  logic i_fixed,
  output logic o_grant,
  output logic o_valid
);

  always_comb begin
    o_valid = i_req0 | i_req1;
    o_grant = PORT_CPU;
    // Only a tie consults history; a lone requester always wins.
    if (i_req0 && i_req1) begin
      o_grant = i_fixed ? PORT_CPU : ~i_last_grant;
    end else if (i_req1) begin
      o_grant = PORT_AUX;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares one single-port block RAM between the CPU and a secondary master
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 12,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_arbiter_if.slave          p0,
  ram_arbiter_if.slave          p1,
  output logic [ADDR_WIDTH-1:0] o_ram_address_bus,
  output logic                  o_ram_enable,
  output logic                  o_ram_write,
  output logic                  o_ram_read,
  inout  wire  [DATA_WIDTH-1:0] io_ram_data_bus
);

  localparam logic FIXED_EN = (FIXED_PRIORITY != 0);

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_grant;
  logic                  r_last_grant;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_wdata;
  logic [7:0]            r_rdata0;
  logic [7:0]            r_rdata1;
  logic                  w_arb_grant;
  logic                  w_arb_valid;
  logic                  w_start;
  logic                  w_ack0;
  logic                  w_ack1;

  rr_arbiter2 u_rr (
    .i_req0       (p0.req),
    .i_req1       (p1.req),
    .i_last_grant (r_last_grant),
    .i_fixed      (FIXED_EN),
    .o_grant      (w_arb_grant),
    .o_valid      (w_arb_valid)
  );

  assign w_start = (r_state == ST_IDLE) && w_arb_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Requests are sampled only in IDLE, so a master dropping req later cannot abort a transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant      <= PORT_CPU;
      r_last_grant <= PORT_AUX;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      if (w_start) begin
        r_grant      <= w_arb_grant;
        r_last_grant <= w_arb_grant;
        if (w_arb_grant == PORT_AUX) begin
          r_we    <= p1.we;
          r_addr  <= p1.addr;
          r_wdata <= p1.wdata;
        end else begin
          r_we    <= p0.we;
          r_addr  <= p0.addr;
          r_wdata <= p0.wdata;
        end
      end
      if (r_state == ST_READ) begin
        if (r_grant == PORT_AUX) begin
          r_rdata1 <= io_ram_data_bus;
        end else begin
          r_rdata0 <= io_ram_data_bus;
        end
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_arb_valid) w_next_state = ST_ACCESS;
      ST_ACCESS: w_next_state = r_we ? ST_ACK : ST_READ;
      ST_READ:   w_next_state = ST_ACK;
      ST_ACK:    w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    o_ram_address_bus = r_addr;
    o_ram_enable      = 1'b0;
    o_ram_write       = 1'b0;
    o_ram_read        = 1'b0;
    w_ack0            = 1'b0;
    w_ack1            = 1'b0;
    case (r_state)
      ST_ACCESS: begin
        o_ram_enable = 1'b1;
        o_ram_write  = r_we;
      end
      ST_READ: o_ram_read = 1'b1;
      ST_ACK: begin
        w_ack0 = (r_grant == PORT_CPU);
        w_ack1 = (r_grant == PORT_AUX);
      end
      default: ;
    endcase
  end

  assign p0.ack   = w_ack0;
  assign p1.ack   = w_ack1;
  assign p0.rdata = r_rdata0;
  assign p1.rdata = r_rdata1;

  // Drive only during a write strobe; the RAM owns the bus whenever ram_read is high.
  assign io_ram_data_bus = o_ram_write ? r_wdata : {DATA_WIDTH{1'bz}};

endmodule
